// File: rtl/aer_pkg.sv
// Shared types and default sizing for the AER spike encoder.
package aer_pkg;

  localparam int N_NEURONS_DEF   = 32;
  localparam int ADDR_WIDTH_DEF  = 5;
  localparam int TIMER_WIDTH_DEF = 5;
  localparam int TOTAL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EOS  = 2'd2
  } aer_state_e;

  // True when aw address bits can name every one of n neurons.
  function automatic bit addr_width_ok(input int n, input int aw);
    return $clog2(n) <= aw;
  endfunction

endpackage

// File: rtl/spike_priority_encoder.sv
// Lowest-set-bit finder: index, any-set flag, isolated bit and its clear mask.
module spike_priority_encoder #(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic [N-1:0]  vec,
  output logic [AW-1:0] idx,
  output logic          any,
  output logic [N-1:0]  one_hot,
  output logic [N-1:0]  one_hot_clear
);

  // Scan from the top so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = AW'(i);
    end
  end

  assign any           = |vec;
  assign one_hot       = vec & (~vec + N'(1));
  assign one_hot_clear = ~one_hot;

endmodule

// File: rtl/aer_spike_encoder.sv
// Serialises a per-timestep spike vector into AER beats plus an end-of-step marker.
module aer_spike_encoder
  import aer_pkg::*;
#(
  parameter int N_NEURONS   = N_NEURONS_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TIMER_WIDTH = TIMER_WIDTH_DEF,
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_NEURONS-1:0]   in_spikes,
  input  logic [TIMER_WIDTH-1:0] in_timestep,
  input  logic                   in_last,
  output logic                   aer_valid,
  input  logic                   aer_ready,
  output logic [ADDR_WIDTH-1:0]  aer_addr,
  output logic [TIMER_WIDTH-1:0] aer_timestep,
  output logic                   aer_eos,
  output logic                   aer_last,
  output logic [ADDR_WIDTH:0]    aer_count,
  output logic [TOTAL_WIDTH-1:0] total_events
);

  localparam int CW = ADDR_WIDTH + 1;

  if (!addr_width_ok(N_NEURONS, ADDR_WIDTH)) begin : g_bad_addr_width
    $error("ADDR_WIDTH too small for N_NEURONS");
  end

  aer_state_e             state_q, state_d;
  logic [N_NEURONS-1:0]   pending_q, pending_d;
  logic [TIMER_WIDTH-1:0] ts_q, ts_d;
  logic                   last_q, last_d;
  logic [CW-1:0]          step_q, step_d;
  logic [TOTAL_WIDTH-1:0] total_q, total_d;

  logic [ADDR_WIDTH-1:0]  low_idx;
  logic                   low_any;
  logic [N_NEURONS-1:0]   low_bit;
  logic [N_NEURONS-1:0]   low_clr;
  logic [N_NEURONS-1:0]   pending_next;

  spike_priority_encoder #(
    .N  (N_NEURONS),
    .AW (ADDR_WIDTH)
  ) u_prio (
    .vec           (pending_q),
    .idx           (low_idx),
    .any           (low_any),
    .one_hot       (low_bit),
    .one_hot_clear (low_clr)
  );

  assign pending_next = pending_q & low_clr;

  // in_ready is masked by rst so nothing is captured on a reset edge.
  assign in_ready     = (state_q == IDLE) && !rst;
  assign aer_valid    = (state_q != IDLE);
  assign aer_eos      = (state_q == EOS);
  assign aer_addr     = (state_q == SCAN) ? low_idx : '0;
  assign aer_timestep = aer_valid ? ts_q : '0;
  assign aer_last     = aer_eos & last_q;
  assign aer_count    = aer_eos ? step_q : '0;
  assign total_events = total_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ts_d      = ts_q;
    last_d    = last_q;
    step_d    = step_q;
    total_d   = total_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pending_d = in_spikes;
          ts_d      = in_timestep;
          last_d    = in_last;
          step_d    = '0;
          state_d   = (|in_spikes) ? SCAN : EOS;
        end
      end
      SCAN: begin
        if (aer_ready && low_any) begin
          pending_d = pending_next;
          step_d    = step_q + CW'(1);
          if (total_q != {TOTAL_WIDTH{1'b1}}) total_d = total_q + TOTAL_WIDTH'(1);
          if (!(|pending_next)) state_d = EOS;
        end
      end
      EOS: begin
        if (aer_ready) begin
          state_d = IDLE;
          if (last_q) total_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ts_q      <= '0;
      last_q    <= 1'b0;
      step_q    <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ts_q      <= ts_d;
      last_q    <= last_d;
      step_q    <= step_d;
      total_q   <= total_d;
    end
  end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench: queue-of-beats model checked every cycle, plus literal beat checks.
module tb_aer_spike_encoder;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_spikes = '0;
  logic [TW-1:0] in_timestep = '0;
  logic          in_last = 1'b0;
  logic          aer_ready = 1'b1;

  logic          in_ready, aer_valid, aer_eos, aer_last;
  logic [AW-1:0] aer_addr;
  logic [TW-1:0] aer_timestep;
  logic [AW:0]   aer_count;
  logic [15:0]   total_w;

  logic          s_in_ready, s_aer_valid, s_aer_eos, s_aer_last;
  logic [AW-1:0] s_aer_addr;
  logic [TW-1:0] s_aer_timestep;
  logic [AW:0]   s_aer_count;
  logic [3:0]    total_s;

  aer_spike_encoder #(.N_NEURONS(N), .ADDR_WIDTH(AW), .TIMER_WIDTH(TW), .TOTAL_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .in_timestep(in_timestep), .in_last(in_last), .aer_valid(aer_valid), .aer_ready(aer_ready),
    .aer_addr(aer_addr), .aer_timestep(aer_timestep), .aer_eos(aer_eos), .aer_last(aer_last),
    .aer_count(aer_count), .total_events(total_w));

  aer_spike_encoder #(.N_NEURONS(N), .ADDR_WIDTH(AW), .TIMER_WIDTH(TW), .TOTAL_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_spikes(in_spikes),
    .in_timestep(in_timestep), .in_last(in_last), .aer_valid(s_aer_valid), .aer_ready(aer_ready),
    .aer_addr(s_aer_addr), .aer_timestep(s_aer_timestep), .aer_eos(s_aer_eos), .aer_last(s_aer_last),
    .aer_count(s_aer_count), .total_events(total_s));

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit eos;
    bit last;
    int count;
    int ts;
  } beat_t;

  beat_t mq[$];
  beat_t seen[$];
  int    mtotal = 0;
  bit    chk_en = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model: an accepted vector expands into its event beats plus a marker.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mtotal = 0;
    end else if (mq.size() != 0) begin
      if (aer_ready) begin
        beat_t b;
        b = mq.pop_front();
        if (b.eos) begin
          if (b.last) mtotal = 0;
        end else begin
          mtotal++;
        end
      end
    end else if (in_valid) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (in_spikes[i]) begin
          mq.push_back('{i, 1'b0, 1'b0, 0, int'(in_timestep)});
          cnt++;
        end
      end
      mq.push_back('{0, 1'b1, in_last, cnt, int'(in_timestep)});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      beat_t e;
      bit    ev;
      ev = (mq.size() != 0);
      e  = ev ? mq[0] : '{0, 1'b0, 1'b0, 0, 0};
      chk("in_ready", int'(in_ready), int'(mq.size() == 0 && !rst));
      chk("aer_valid", int'(aer_valid), int'(ev));
      chk("aer_addr", int'(aer_addr), e.addr);
      chk("aer_eos", int'(aer_eos), int'(e.eos));
      chk("aer_last", int'(aer_last), int'(e.last));
      chk("aer_count", int'(aer_count), e.count);
      chk("aer_timestep", int'(aer_timestep), e.ts);
      chk("total_events", int'(total_w), sat(mtotal, 65535));
      chk("sat_in_ready", int'(s_in_ready), int'(mq.size() == 0 && !rst));
      chk("sat_aer_valid", int'(s_aer_valid), int'(ev));
      chk("sat_aer_addr", int'(s_aer_addr), e.addr);
      chk("sat_aer_eos", int'(s_aer_eos), int'(e.eos));
      chk("sat_aer_last", int'(s_aer_last), int'(e.last));
      chk("sat_aer_count", int'(s_aer_count), e.count);
      chk("sat_aer_timestep", int'(s_aer_timestep), e.ts);
      chk("sat_total_events", int'(total_s), sat(mtotal, 15));
    end
  end

  always @(posedge clk) begin
    if (chk_en && !rst && aer_valid && aer_ready)
      seen.push_back('{int'(aer_addr), aer_eos, aer_last, int'(aer_count), int'(aer_timestep)});
  end

  task automatic send(input logic [N-1:0] sp, input int t, input bit l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_spikes = sp;
    in_timestep = t[TW-1:0];
    in_last = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept_timeout", int'(ok), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (mq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) aer_ready = 1'($urandom_range(0, 1));
    end
    aer_ready = 1'b1;
    chk("drain_timeout", int'(ok), 1);
  endtask

  task automatic check_beat(input int idx, input int addr, input bit eos, input bit last, input int count);
    if (idx >= seen.size()) begin
      chk("beat_missing", idx, seen.size());
    end else begin
      chk("beat_addr", seen[idx].addr, addr);
      chk("beat_eos", int'(seen[idx].eos), int'(eos));
      chk("beat_last", int'(seen[idx].last), int'(last));
      chk("beat_count", seen[idx].count, count);
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_total", int'(total_w), 0);
    @(posedge clk);
    #1;

    // All-zero vector: lone marker, in_ready back two cycles after accept.
    seen.delete();
    send('0, 3, 1'b0);
    @(negedge clk);
    chk("t1_eos", int'(aer_eos), 1);
    chk("t1_count", int'(aer_count), 0);
    chk("t1_ts", int'(aer_timestep), 3);
    chk("t1_ready_busy", int'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_ready_back", int'(in_ready), 1);
    chk("t1_beats", seen.size(), 1);
    check_beat(0, 0, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1;

    seen.delete();
    send(32'h8000_0011, 1, 1'b0);
    drain(1'b0);
    chk("t2_beats", seen.size(), 4);
    check_beat(0, 0, 1'b0, 1'b0, 0);
    check_beat(1, 4, 1'b0, 1'b0, 0);
    check_beat(2, 31, 1'b0, 1'b0, 0);
    check_beat(3, 0, 1'b1, 1'b0, 3);
    chk("t2_total", int'(total_w), 3);

    // All ones under random backpressure, with ignored vectors offered while busy.
    seen.delete();
    send('1, 2, 1'b1);
    in_valid = 1'b1;
    in_spikes = 32'h5;
    repeat (4) begin
      @(posedge clk);
      #1 aer_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    drain(1'b1);
    chk("t3_beats", seen.size(), 33);
    for (int i = 0; i < 32; i++) check_beat(i, i, 1'b0, 1'b0, 0);
    check_beat(32, 0, 1'b1, 1'b1, 32);
    chk("t3_total_cleared", int'(total_w), 0);

    seen.delete();
    send(32'h0000_0300, 4, 1'b0);
    drain(1'b0);
    send(32'h0000_8001, 5, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (aer_valid && aer_eos) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_marker_seen", int'(found), 1);
    chk("t4_total_before", int'(total_w), 4);
    @(posedge clk);
    @(negedge clk);
    chk("t4_total_after", int'(total_w), 0);
    chk("t4_sat_total_after", int'(total_s), 0);
    check_beat(2, 0, 1'b1, 1'b0, 2);
    check_beat(5, 0, 1'b1, 1'b1, 2);
    @(posedge clk);
    #1;

    // Reset mid-scan after two of five events: no marker, everything zero.
    seen.delete();
    send(32'h0000_1F00, 6, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", int'(aer_valid), 0);
    chk("t5_addr", int'(aer_addr), 0);
    chk("t5_eos", int'(aer_eos), 0);
    chk("t5_count", int'(aer_count), 0);
    chk("t5_total", int'(total_w), 0);
    chk("t5_ready", int'(in_ready), 1);
    chk("t5_beats", seen.size(), 2);
    check_beat(0, 8, 1'b0, 1'b0, 0);
    check_beat(1, 9, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    seen.delete();
    send(32'h1, 7, 1'b0);
    drain(1'b0);
    chk("t5b_beats", seen.size(), 2);
    check_beat(0, 0, 1'b0, 1'b0, 0);
    check_beat(1, 0, 1'b1, 1'b0, 1);

    // Saturation of the narrow total; markers keep the true per-step count.
    seen.delete();
    for (int v = 0; v < 5; v++) begin
      logic [N-1:0] sp;
      sp = 32'hF << (v * 4);
      send(sp, 8 + v, 1'b0);
      drain(1'b0);
    end
    chk("t6_beats", seen.size(), 25);
    for (int v = 0; v < 5; v++) check_beat(v * 5 + 4, 0, 1'b1, 1'b0, 4);
    chk("t6_sat_total", int'(total_s), 15);
    chk("t6_wide_total", int'(total_w), 21);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aer_spike_encoder.md
# aer_spike_encoder

Converts the per-timestep parallel spike vector produced by the activation unit (one `out_spike_*` bit per neuron) into a serial address-event (AER) stream. It sits directly downstream of the activation unit and upstream of the output/event interface. Each accepted vector becomes one beat per set bit, in ascending neuron order, followed by one end-of-step marker beat. Both sides use valid/ready handshakes.

## Interface
Parameters:
- `N_NEURONS`, 32, width of the spike vector (one bit per activation element).
- `ADDR_WIDTH`, 5, neuron address width; must satisfy 2^ADDR_WIDTH >= N_NEURONS.
- `TIMER_WIDTH`, 5, timestep tag width; matches the activation unit's `TIMER_WIDTH`.
- `TOTAL_WIDTH`, 16, width of the saturating per-window event total.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  spike vector presented.
- `in_ready`  out  1  encoder can accept a vector.
- `in_spikes`  in  N_NEURONS  bit i = spike of neuron i for this timestep.
- `in_timestep`  in  TIMER_WIDTH  timestep tag of the vector.
- `in_last`  in  1  vector is the final timestep of the inference window.
- `aer_valid`  out  1  event beat valid.
- `aer_ready`  in  1  downstream accepts beat.
- `aer_addr`  out  ADDR_WIDTH  neuron address; 0 on marker beats.
- `aer_timestep`  out  TIMER_WIDTH  captured timestep tag.
- `aer_eos`  out  1  beat is the end-of-step marker.
- `aer_last`  out  1  on marker beat only: captured `in_last`.
- `aer_count`  out  ADDR_WIDTH+1  on marker beat: number of events emitted this step; 0 otherwise.
- `total_events`  out  TOTAL_WIDTH  saturating event count for the current window.

## Operation
- States: IDLE, SCAN, EOS.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `in_spikes` into `pending`, and also capture `in_timestep` and `in_last`. Clear `step_count`. Go to SCAN if vector nonzero, else to EOS.
- SCAN: `aer_valid`=1, `aer_eos`=0, `aer_addr` = index of the lowest set bit of `pending`. On `aer_ready`:
  - clear that bit;
  - `step_count`+1;
  - `total_events`+1, saturating at 2^TOTAL_WIDTH-1.
  - If that was the last set bit, go to EOS; else stay in SCAN.
- EOS: `aer_valid`=1, `aer_eos`=1, `aer_addr`=0, `aer_count`=`step_count`, `aer_last`=captured last. On `aer_ready`, go to IDLE. If captured last=1, `total_events` clears to 0 on that same edge.
- `in_ready`=0 in SCAN and EOS; vectors are never dropped, and upstream stalls.
- AXI-style rule: once `aer_valid` rises, it and all `aer_*` payload stay stable until `aer_ready` is sampled high. `aer_valid` never depends combinationally on `aer_ready`.
- `aer_last` and `aer_count` are 0 on non-marker beats.
- `total_events` saturation does not affect `aer_count`. `aer_count` max = N_NEURONS, and it never wraps.

## Timing
- Reset (any state, mid-step included): state IDLE, `pending`=0, `step_count`=0, `total_events`=0, all `aer_*` outputs 0. No marker is emitted for an aborted step. `in_ready`=0 while `rst` is high, and 1 in the first cycle after release.
- Latency: a vector accepted at edge t gives `aer_valid`=1 from cycle t+1.
- Throughput: with `aer_ready` held high, one beat per cycle. A vector with k spikes occupies k+1 output cycles plus 1 accept cycle, so `in_ready` returns the cycle after the marker handshake.
- All-zero vector: exactly one marker beat with `aer_count`=0.
- All-ones vector (32 neurons): addresses 0..31 in order, then a marker with `aer_count`=32.
- `aer_ready` deasserted: the beat holds indefinitely, and state and counters do not advance.
- `in_valid` while `in_ready`=0: ignored, with no capture.

## Structure
- Shared package `aer_pkg`:
  - state enum {IDLE, SCAN, EOS};
  - default `N_NEURONS`/`ADDR_WIDTH`/`TIMER_WIDTH` constants;
  - a `clog2`-based address-width check.
- Sub-module `spike_priority_encoder` (combinational): N-bit input, outputs the lowest-set-bit index, plus `any` and `one_hot_clear` masks. It is instantiated once.
- Top: FSM, capture registers, counters.

## Test plan
- Reset, then `in_spikes`=32'h0000_0000, timestep 3, `aer_ready`=1 → single beat: eos=1, count=0, timestep=3; `in_ready` high again 2 cycles after accept.
- `in_spikes`=32'h8000_0011, `in_last`=0 → beats addr 0, 4, 31, then a marker with count=3 and last=0; `total_events`=3.
- `in_spikes`=32'hFFFF_FFFF with `aer_ready` toggled randomly → addresses 0..31 strictly ascending, each held stable while stalled; marker count=32.
- Two vectors of 2 spikes each, the second with `in_last`=1 → second marker has last=1; `total_events` reads 4 before, and 0 after, that marker handshake.
- `rst` pulsed while in SCAN after 2 of 5 events → all outputs 0 next cycle, no marker; a subsequent vector 32'h1 yields addr 0 then a marker with count=1.
- Force `total_events` near saturation (TOTAL_WIDTH=4 build, 5 vectors of 4 spikes) → `total_events` sticks at 15; each marker still shows count=4.
